// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
//   Issues word-aligned sequential fetch requests over a valid/ready channel. Responses come
//   back in order and are buffered, with their PCs, in a prefetch FIFO that feeds the decoder.
//   A redirect flushes the FIFO and restarts fetch at the target. Responses to requests issued
//   before the redirect are dropped as they arrive.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       fetch request channel
//   imem_rsp_valid/data             in-order fetch responses, always accepted
//   redirect_valid/addr             taken branch/jump, one-cycle pulse
//   instr_valid/ready/out/pc        decoder channel (FIFO head)
//   perf_fetched/dropped/stall      performance counters, present only with FETCH_PERF_EN
// Optional feature macro: FETCH_PERF_EN
module fetch_unit #(
    parameter int unsigned      XLEN            = 32,
    parameter int unsigned      ILEN            = 32,
    parameter logic [XLEN-1:0]  RESET_PC        = 32'h0000_0000,
    parameter int unsigned      FIFO_DEPTH      = 4,
    parameter int unsigned      MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped,
    output logic [31:0]     perf_stall
`endif
);

    localparam int unsigned FAW = $clog2(FIFO_DEPTH);
    localparam int unsigned FPW = FAW + 1;
    localparam int unsigned QAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    // run_q keeps the request channel quiet for the first cycle after reset release.
    logic                 run_q;
    logic [XLEN-1:0]      fetch_pc_q;
    logic [OCW-1:0]       outstanding_q, outstanding_d;
    logic [OCW-1:0]       drop_q, drop_d;

    // Prefetch FIFO; one extra pointer bit separates full from empty.
    logic [FPW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [ILEN-1:0]      fifo_data_q [FIFO_DEPTH];
    logic [XLEN-1:0]      fifo_pc_q   [FIFO_DEPTH];
    logic [FPW-1:0]       fifo_count;
    logic                 fifo_empty;

    // PCs of issued requests, in issue order, waiting for their responses.
    logic [XLEN-1:0]      pcq_q [MAX_OUTSTANDING];
    logic [QAW-1:0]       pcq_wr_q, pcq_rd_q;

    logic                 credit_ok;
    logic                 req_fire;
    logic                 rsp_fire;
    logic                 push;
    logic                 pop;

    function automatic logic [QAW-1:0] pcq_next(input logic [QAW-1:0] ptr);
        if (ptr == QAW'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return ptr + QAW'(1);
    endfunction

    always_comb begin
        fifo_count = wr_ptr_q - rd_ptr_q;
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        // Reserving a FIFO slot per in-flight request means responses never find the FIFO full.
        credit_ok  = ((32'(fifo_count) + 32'(outstanding_q)) < FIFO_DEPTH) &&
                     (32'(outstanding_q) < MAX_OUTSTANDING);

        imem_req_valid = run_q && credit_ok && !redirect_valid;
        imem_req_addr  = fetch_pc_q & ALIGN_MASK;

        req_fire = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp_fire = imem_rsp_valid && (outstanding_q != '0);
        push     = rsp_fire && (drop_q == '0) && !redirect_valid;

        instr_valid = !fifo_empty;
        instr_out   = fifo_empty ? '0 : fifo_data_q[rd_ptr_q[FAW-1:0]];
        instr_pc    = fifo_empty ? '0 : fifo_pc_q[rd_ptr_q[FAW-1:0]];
        pop         = instr_valid && instr_ready && !redirect_valid;

        outstanding_d = outstanding_q;
        if (req_fire && !rsp_fire) begin
            outstanding_d = outstanding_q + OCW'(1);
        end else if (!req_fire && rsp_fire) begin
            outstanding_d = outstanding_q - OCW'(1);
        end

        drop_d = drop_q;
        if (redirect_valid) begin
            // No request can issue in a redirect cycle, so everything still in flight is stale.
            drop_d = outstanding_d;
        end else if (rsp_fire && (drop_q != '0)) begin
            drop_d = drop_q - OCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
        end else begin
            run_q         <= 1'b1;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;

            if (redirect_valid) begin
                fetch_pc_q <= redirect_addr & ALIGN_MASK;
            end else if (req_fire) begin
                fetch_pc_q <= imem_req_addr + XLEN'(4);
            end

            if (req_fire) begin
                pcq_wr_q <= pcq_next(pcq_wr_q);
            end
            if (rsp_fire) begin
                pcq_rd_q <= pcq_next(pcq_rd_q);
            end

            if (redirect_valid) begin
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + FPW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + FPW'(1);
                end
            end
        end
    end

    // Storage arrays carry no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_q[pcq_wr_q] <= imem_req_addr;
        end
        if (push) begin
            fifo_data_q[wr_ptr_q[FAW-1:0]] <= imem_rsp_data;
            fifo_pc_q[wr_ptr_q[FAW-1:0]]   <= pcq_q[pcq_rd_q];
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            // Discarded responses plus entries thrown away by a flush.
            perf_dropped <= perf_dropped + ((rsp_fire && !push) ? 32'd1 : 32'd0) +
                            (redirect_valid ? 32'(fifo_count) : 32'd0);
            if (!instr_valid) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit.
//   A behavioural memory answers requests in order after a random latency with data equal to
//   the word index of the request address. The reference model is the architectural view:
//   the decoder must see PCs rising by 4 from the last redirect target (or RESET_PC), each
//   paired with the word index of its PC, and requests must go out at the expected addresses.
// Optional feature macro: FETCH_PERF_EN
module tb_fetch_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned MAX_OUTSTANDING = 2;

    logic            clk;
    logic            rst_n;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_addr;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr_out;
    logic [XLEN-1:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_dropped;
    logic [31:0]     perf_stall;
`endif

    fetch_unit #(
        .XLEN            (XLEN),
        .ILEN            (ILEN),
        .RESET_PC        (RESET_PC),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Memory model: in-order queue of request addresses and the cycle each response is due.
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          last_due = 0;

    // Stimulus knobs.
    int   ready_mode = 0;  // 0: always ready, 1: toggle each cycle, 2: random
    int   lat_min = 1;
    int   lat_max = 1;
    bit   dec_stall = 1'b0;
    bit   dec_rand = 1'b0;
    bit   redir_req = 1'b0;
    logic [31:0] redir_target = '0;

    // Architectural reference state.
    logic [31:0] exp_out;
    logic [31:0] exp_fetch;
    int          consumed;
    bit          prev_redirect;
    bit          hold_pending;
    logic [31:0] hold_addr;

    task automatic model_reset();
        mq_addr.delete();
        mq_due.delete();
        last_due      = 0;
        exp_out       = RESET_PC;
        exp_fetch     = RESET_PC;
        consumed      = 0;
        prev_redirect = 1'b0;
        hold_pending  = 1'b0;
        redir_req     = 1'b0;
    endtask

    task automatic quiet_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        instr_ready    = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, observe settled outputs 1 time unit
    // later, and advance the reference model by whatever handshakes occur this cycle.
    task automatic tick();
        int lat;
        int due;
        logic [31:0] tgt;
        @(negedge clk);
        case (ready_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = (cyc % 2) == 0;
            default: imem_req_ready = ($urandom_range(0, 1) == 1);
        endcase
        if (dec_stall)     instr_ready = 1'b0;
        else if (dec_rand) instr_ready = ($urandom_range(0, 3) != 0);
        else               instr_ready = 1'b1;
        redirect_valid = redir_req;
        redirect_addr  = redir_target;
        redir_req      = 1'b0;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq_addr[0] >> 2;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        if (hold_pending && !redirect_valid) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== hold_addr) begin
                errors++;
                $display("FAIL req_stable: valid=%b addr=%h required valid=1 addr=%h",
                         imem_req_valid, imem_req_addr, hold_addr);
            end
        end
        if (prev_redirect) begin
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_after_redirect: got %b required 0", instr_valid);
            end
        end
        if (redirect_valid) begin
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL req_during_redirect: got %b required 0", imem_req_valid);
            end
        end
        if (imem_rsp_valid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (imem_req_valid === 1'b1 && imem_req_ready) begin
            checks++;
            if (imem_req_addr !== exp_fetch) begin
                errors++;
                $display("FAIL req_addr: got %h required %h", imem_req_addr, exp_fetch);
            end
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(due);
            exp_fetch = exp_fetch + 32'd4;
        end
        hold_pending = (imem_req_valid === 1'b1) && !imem_req_ready;
        hold_addr    = imem_req_addr;
        if (instr_valid === 1'b1 && instr_ready && !redirect_valid) begin
            checks++;
            if (instr_pc !== exp_out || instr_out !== (exp_out >> 2)) begin
                errors++;
                $display("FAIL stream: pc=%h data=%h required pc=%h data=%h",
                         instr_pc, instr_out, exp_out, exp_out >> 2);
            end
            exp_out = exp_out + 32'd4;
            consumed++;
        end
        if (redirect_valid) begin
            tgt       = redirect_addr & 32'hFFFF_FFFC;
            exp_out   = tgt;
            exp_fetch = tgt;
        end
        checks++;
        if (mq_addr.size() > MAX_OUTSTANDING) begin
            errors++;
            $display("FAIL outstanding_limit: got %0d required <= %0d",
                     mq_addr.size(), MAX_OUTSTANDING);
        end
        prev_redirect = redirect_valid;
        cyc++;
    endtask

    // Runs cycles until instr_valid is seen; ok=0 if the budget expires.
    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        quiet_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        quiet_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC || instr_valid !== 1'b0 ||
            instr_out !== '0 || instr_pc !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rv=%b ra=%h iv=%b io=%h ip=%h required 0 %h 0 0 0",
                     imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc, RESET_PC);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL req_after_release: got %b required 0", imem_req_valid);
        end
        ready_mode = 0; lat_min = 1; lat_max = 1; dec_stall = 1'b0; dec_rand = 1'b0;
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_request: valid=%b addr=%h required 1 %h",
                     imem_req_valid, imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_zero_wait();
        int first_req;
        int first_valid;
        int gaps;
        apply_reset();
        ready_mode = 0; lat_min = 1; lat_max = 1; dec_stall = 1'b0; dec_rand = 1'b0;
        first_req = -1;
        first_valid = -1;
        for (int i = 0; i < 20 && first_valid < 0; i++) begin
            tick();
            if (imem_req_valid === 1'b1 && imem_req_ready && first_req < 0) first_req = cyc;
            if (instr_valid === 1'b1) begin
                first_valid = cyc;
                checks++;
                if (instr_pc !== 32'h0 || instr_out !== 32'h0) begin
                    errors++;
                    $display("FAIL first_instr: pc=%h data=%h required 0 0", instr_pc, instr_out);
                end
            end
        end
        checks++;
        if (first_req < 0 || first_valid - first_req != 2) begin
            errors++;
            $display("FAIL fetch_latency: got %0d cycles required 2", first_valid - first_req);
        end
        gaps = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (instr_valid !== 1'b1) gaps++;
        end
        checks++;
        if (gaps != 0 || consumed != 21) begin
            errors++;
            $display("FAIL throughput: gaps=%0d consumed=%0d required gaps=0 consumed=21",
                     gaps, consumed);
        end
    endtask

    task automatic test_decoder_stall();
        bit ok;
        apply_reset();
        ready_mode = 0; lat_min = 1; lat_max = 1; dec_rand = 1'b0;
        dec_stall = 1'b1;
        repeat (12) tick();
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0 ||
            mq_addr.size() != 0) begin
            errors++;
            $display("FAIL stall_full: rv=%b iv=%b pc=%h inflight=%0d required 0 1 0 0",
                     imem_req_valid, instr_valid, instr_pc, mq_addr.size());
        end
        dec_stall = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = (consumed >= 6);
        end
        checks++;
        if (!ok || exp_fetch <= 32'h10) begin
            errors++;
            $display("FAIL stall_release: consumed=%0d next_fetch=%h required >=6 >10",
                     consumed, exp_fetch);
        end
    endtask

    task automatic test_redirect_drop();
        bit ok;
        apply_reset();
        ready_mode = 0; lat_min = 3; lat_max = 3; dec_stall = 1'b0; dec_rand = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = (mq_addr.size() == 2);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL two_outstanding: got %0d required 2", mq_addr.size());
        end
        redir_req = 1'b1;
        redir_target = 32'h100;
        tick();
        wait_valid(40, ok);
        checks++;
        if (!ok || instr_pc !== 32'h100 || instr_out !== 32'h40) begin
            errors++;
            $display("FAIL redirect_target: pc=%h data=%h required 100 40", instr_pc, instr_out);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        apply_reset();
        ready_mode = 0; lat_min = 2; lat_max = 2; dec_stall = 1'b0; dec_rand = 1'b0;
        repeat (5) tick();
        redir_req = 1'b1; redir_target = 32'h200;
        tick();
        redir_req = 1'b1; redir_target = 32'h300;
        tick();
        wait_valid(40, ok);
        checks++;
        if (!ok || instr_pc !== 32'h300) begin
            errors++;
            $display("FAIL last_redirect_wins: pc=%h required 300", instr_pc);
        end
        redir_req = 1'b1; redir_target = 32'h203;
        tick();
        wait_valid(40, ok);
        checks++;
        if (!ok || instr_pc !== 32'h200 || instr_out !== 32'h80) begin
            errors++;
            $display("FAIL unaligned_redirect: pc=%h data=%h required 200 80",
                     instr_pc, instr_out);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        ready_mode = 0; lat_min = 3; lat_max = 3; dec_rand = 1'b0;
        dec_stall = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            ok = (mq_addr.size() == 2) && (instr_valid === 1'b1);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL prefill: inflight=%0d iv=%b required 2 1", mq_addr.size(), instr_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC || instr_valid !== 1'b0 ||
            instr_out !== '0 || instr_pc !== '0) begin
            errors++;
            $display("FAIL async_reset: rv=%b ra=%h iv=%b io=%h ip=%h required 0 %h 0 0 0",
                     imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc, RESET_PC);
        end
        quiet_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dec_stall = 1'b0;
        wait_valid(40, ok);
        checks++;
        if (!ok || instr_pc !== RESET_PC || instr_out !== (RESET_PC >> 2)) begin
            errors++;
            $display("FAIL restart_after_reset: pc=%h data=%h required %h", instr_pc, instr_out,
                     RESET_PC);
        end
    endtask

    task automatic test_random_stream();
        bit ok;
        apply_reset();
        ready_mode = 1; lat_min = 1; lat_max = 5; dec_stall = 1'b0; dec_rand = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30000 && !ok; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                redir_req = 1'b1;
                redir_target = $urandom_range(0, 32'hFFFF);
            end
            tick();
            ok = (consumed >= 1000);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL random_stream: consumed=%0d required >= 1000", consumed);
        end
        // One idle cycle so the last pop is registered in the counter.
        dec_stall = 1'b1;
        dec_rand = 1'b0;
        tick();
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_fetched !== 32'(consumed)) begin
            errors++;
            $display("FAIL perf_fetched: got %0d required %0d", perf_fetched, consumed);
        end
`endif
    endtask

    initial begin
        quiet_inputs();
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_zero_wait();
        test_decoder_stall();
        test_redirect_drop();
        test_back_to_back();
        test_async_reset();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
